// File: rtl/uart_rx_unit_pkg.sv
// Shared types and helpers for the UART receiver and its FIFO.
// Status-register bit positions and load addresses live in the shared uart_defs.v include.
package uart_rx_unit_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  // Returns b with bit idx replaced by v.
  function automatic logic [7:0] set_bit(input logic [7:0] b, input logic [2:0] idx,
                                         input logic v);
    logic [7:0] r;
    r      = b;
    r[idx] = v;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// Load-path view of the UART receiver: FIFO pop, head data, occupancy and sticky status.
interface uart_rx_unit_if #(
  parameter int unsigned DEPTH = 32
);

  logic                     uart_fifo_read_en;
  logic [7:0]               uart_fifo_data;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     status_clear;
  logic                     overrun;
  logic                     frame_error;

  // master: the load path that pops bytes and clears status
  modport master (
    output uart_fifo_read_en,
    output status_clear,
    input  uart_fifo_data,
    input  fifo_empty,
    input  fifo_count,
    input  overrun,
    input  frame_error
  );

  // slave: the receiver that owns the FIFO and flags
  modport slave (
    input  uart_fifo_read_en,
    input  status_clear,
    output uart_fifo_data,
    output fifo_empty,
    output fifo_count,
    output overrun,
    output frame_error
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with show-ahead head, explicit occupancy counter and push-while-full-and-popping rule.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, full;
  logic            pop_eff, push_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign pop_eff  = pop_i & ~empty;
  assign push_eff = push_i & (~full | pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_eff) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign empty_o = empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver: synchronises the RX line, deserialises frames mid-bit and queues bytes
// in a FIFO read by the load path, with sticky overrun and framing-error flags.
module uart_rx_unit
  import uart_rx_unit_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DEPTH        = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           uart_input_line,
  uart_rx_unit_if.slave  bus
);

  localparam int unsigned TickW = $clog2(CLKS_PER_BIT);
  localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_BIT - 1);
  localparam logic [TickW-1:0] TickHalf = TickW'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             overrun_q, overrun_d;
  logic             frame_error_q, frame_error_d;
  logic             push;
  logic             frame_err_set;
  logic             fifo_full;

  // Two-flop synchroniser, idle-high reset value avoids a false start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_input_line;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end
      StStart: begin
        if (tick_q == TickHalf) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            tick_d    = '0;
            bit_idx_d = '0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StData: begin
        if (tick_q == TickLast) begin
          shift_d = set_bit(shift_q, bit_idx_q, rx_s_q);
          tick_d  = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StStop: begin
        if (tick_q == TickLast) begin
          tick_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_set = 1'b1;
            state_d       = StWaitHigh;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      StWaitHigh: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear wins over a same-cycle set.
  always_comb begin
    overrun_d     = overrun_q | (push & fifo_full & ~bus.uart_fifo_read_en);
    frame_error_d = frame_error_q | frame_err_set;
    if (bus.status_clear) begin
      overrun_d     = 1'b0;
      frame_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      tick_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (bus.uart_fifo_read_en),
    .data_o  (bus.uart_fifo_data),
    .empty_o (bus.fifo_empty),
    .full_o  (fifo_full),
    .count_o (bus.fifo_count)
  );

  assign bus.overrun     = overrun_q;
  assign bus.frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit: single byte, glitch, framing error, overrun,
// full-with-pop and reset mid-frame, with a vector table for the overrun sequence.
module tb_uart_rx_unit;

  localparam int unsigned Cpb   = 16;
  localparam int unsigned Depth = 4;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic line = 1'b1;

  always #5 clk = ~clk;

  uart_rx_unit_if #(.DEPTH(Depth)) bus ();

  uart_rx_unit #(
    .CLKS_PER_BIT(Cpb),
    .DEPTH       (Depth)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_input_line(line),
    .bus            (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         exp_count;
    int         exp_ovr;
    int         exp_head;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v, input int cycles);
    line = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the line idle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_cycles);
    bit_time(1'b0, Cpb);
    for (int i = 0; i < 8; i++) begin
      bit_time(d[i], Cpb);
    end
    bit_time(stop, stop_cycles);
    line = 1'b1;
  endtask

  task automatic pop();
    bus.uart_fifo_read_en = 1'b1;
    @(negedge clk);
    bus.uart_fifo_read_en = 1'b0;
  endtask

  task automatic clear_status();
    bus.status_clear = 1'b1;
    @(negedge clk);
    bus.status_clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  32'(bus.uart_fifo_data), 0);
    check({tag, "_empty"}, 32'(bus.fifo_empty), 1);
    check({tag, "_count"}, 32'(bus.fifo_count), 0);
    check({tag, "_ovr"},   32'(bus.overrun), 0);
    check({tag, "_fe"},    32'(bus.frame_error), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    int   cyc;

    vecs[0] = '{8'h01, 1, 0, 'h01};
    vecs[1] = '{8'h02, 2, 0, 'h01};
    vecs[2] = '{8'h03, 3, 0, 'h01};
    vecs[3] = '{8'h04, 4, 0, 'h01};
    vecs[4] = '{8'h05, 4, 1, 'h01};

    bus.uart_fifo_read_en = 1'b0;
    bus.status_clear      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte with push latency measured from the start edge.
    cyc = 0;
    fork
      send_frame(8'hA5, 1'b1, Cpb);
      begin
        while (bus.fifo_empty && cyc < 400) begin
          @(posedge clk);
          #1;
          cyc++;
        end
      end
    join
    check("a5_latency", 32'(cyc), 155);
    check("a5_data",  32'(bus.uart_fifo_data), 'hA5);
    check("a5_count", 32'(bus.fifo_count), 1);
    pop();
    check("a5_pop_empty", 32'(bus.fifo_empty), 1);
    check("a5_pop_data",  32'(bus.uart_fifo_data), 0);
    pop();
    check("underflow_count", 32'(bus.fifo_count), 0);
    check("underflow_ovr",   32'(bus.overrun), 0);

    // Glitch shorter than half a bit.
    bit_time(1'b0, 5);
    bit_time(1'b1, 30);
    check("glitch_count", 32'(bus.fifo_count), 0);
    check("glitch_fe",    32'(bus.frame_error), 0);
    check("glitch_ovr",   32'(bus.overrun), 0);

    // Framing error with a long break, then a clean frame.
    send_frame(8'h3C, 1'b0, 40);
    repeat (20) @(negedge clk);
    check("fe_set",   32'(bus.frame_error), 1);
    check("fe_count", 32'(bus.fifo_count), 0);
    send_frame(8'h55, 1'b1, Cpb);
    repeat (4) @(negedge clk);
    check("fe_55_count", 32'(bus.fifo_count), 1);
    check("fe_55_data",  32'(bus.uart_fifo_data), 'h55);
    check("fe_sticky",   32'(bus.frame_error), 1);
    clear_status();
    check("fe_cleared",  32'(bus.frame_error), 0);
    pop();

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, 1'b1, Cpb);
      repeat (2) @(negedge clk);
      check($sformatf("ovr_count_%0d", i), 32'(bus.fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("ovr_flag_%0d", i),  32'(bus.overrun), 32'(vecs[i].exp_ovr));
      check($sformatf("ovr_head_%0d", i),  32'(bus.uart_fifo_data), 32'(vecs[i].exp_head));
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovr_read_%0d", i), 32'(bus.uart_fifo_data), 32'(i + 1));
      pop();
    end
    check("ovr_drained", 32'(bus.fifo_empty), 1);
    clear_status();
    check("ovr_cleared", 32'(bus.overrun), 0);

    // Full FIFO with a pop on the push cycle of 0x77.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(8'h11 + i), 1'b1, Cpb);
    end
    check("full_count", 32'(bus.fifo_count), 4);
    fork
      send_frame(8'h77, 1'b1, Cpb);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        bus.uart_fifo_read_en = 1'b1;
        @(posedge clk);
        #1;
        bus.uart_fifo_read_en = 1'b0;
      end
    join
    check("fullrd_ovr",   32'(bus.overrun), 0);
    check("fullrd_count", 32'(bus.fifo_count), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fullrd_read_%0d", i), 32'(bus.uart_fifo_data),
            (i == 3) ? 32'h77 : 32'(8'h12 + i));
      pop();
    end

    // Reset in the middle of data bit 3 of 0xF0, with state to be wiped.
    send_frame(8'h3C, 1'b0, 40);
    repeat (20) @(negedge clk);
    send_frame(8'h99, 1'b1, Cpb);
    repeat (2) @(negedge clk);
    check("prereset_count", 32'(bus.fifo_count), 1);
    check("prereset_fe",    32'(bus.frame_error), 1);
    fork
      send_frame(8'hF0, 1'b1, Cpb);
      begin
        repeat (72) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("midreset");
      end
    join
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h12, 1'b1, Cpb);
    repeat (4) @(negedge clk);
    check("postreset_count", 32'(bus.fifo_count), 1);
    check("postreset_data",  32'(bus.uart_fifo_data), 'h12);
    pop();
    check("postreset_empty", 32'(bus.fifo_empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
